// File: rtl/msrv32_writeback_unit.sv
// Stage-3 writeback: retires ALU results in one cycle and waits for load data from memory.
// Load data is lane-selected and extended here, and stage 2 is stalled while a load is outstanding.
module msrv32_writeback_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        valid_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        rf_wr_en_in,
  input  logic [31:0] alu_result_in,
  input  logic        is_load_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        flush_in,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_rdata_in,
  output logic [4:0]  rd_addr_out,
  output logic        wr_en_out,
  output logic [31:0] rd_out,
  output logic        stall_out,
  output logic        misalign_err_out,
  output logic        timeout_err_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [4:0]       cap_rd_reg, cap_rd_next;
  logic             cap_wr_reg, cap_wr_next;
  logic [1:0]       cap_size_reg, cap_size_next;
  logic             cap_uns_reg, cap_uns_next;
  logic [1:0]       cap_off_reg, cap_off_next;

  logic [4:0]  rd_addr_next;
  logic        wr_en_next;
  logic [31:0] rd_next;
  logic        stall_next;
  logic        misalign_next;
  logic        timeout_next;

  logic        aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Reserved size 2'b11 is reported as misaligned so it never reaches memory.
  always_comb begin
    aligned = 1'b0;
    case (load_size_in)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_result_in[0];
      2'b10:   aligned = (alu_result_in[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata_in[7:0];
    case (cap_off_reg)
      2'd0:    byte_sel = mem_rdata_in[7:0];
      2'd1:    byte_sel = mem_rdata_in[15:8];
      2'd2:    byte_sel = mem_rdata_in[23:16];
      default: byte_sel = mem_rdata_in[31:24];
    endcase
    half_sel = cap_off_reg[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    case (cap_size_reg)
      2'b00:   load_data = {{24{~cap_uns_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~cap_uns_reg & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata_in;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cap_rd_next   = cap_rd_reg;
    cap_wr_next   = cap_wr_reg;
    cap_size_next = cap_size_reg;
    cap_uns_next  = cap_uns_reg;
    cap_off_next  = cap_off_reg;
    rd_addr_next  = rd_addr_out;
    rd_next       = rd_out;
    wr_en_next    = 1'b0;
    stall_next    = 1'b0;
    misalign_next = 1'b0;
    timeout_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (valid_in && !flush_in) begin
          if (!is_load_in) begin
            wr_en_next   = rf_wr_en_in && (rd_addr_in != 5'd0);
            rd_addr_next = rd_addr_in;
            rd_next      = alu_result_in;
          end else if (!aligned) begin
            misalign_next = 1'b1;
          end else begin
            cap_rd_next   = rd_addr_in;
            cap_wr_next   = rf_wr_en_in;
            cap_size_next = load_size_in;
            cap_uns_next  = load_unsigned_in;
            cap_off_next  = alu_result_in[1:0];
            cnt_next      = '0;
            state_next    = S_WAIT;
            stall_next    = 1'b1;
          end
        end
      end
      default: begin
        // Flush takes priority over a same-cycle memory response.
        if (flush_in) begin
          state_next = S_IDLE;
        end else if (mem_ready_in) begin
          wr_en_next   = cap_wr_reg && (cap_rd_reg != 5'd0);
          rd_addr_next = cap_rd_reg;
          rd_next      = load_data;
          state_next   = S_IDLE;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          stall_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      cap_rd_reg       <= '0;
      cap_wr_reg       <= 1'b0;
      cap_size_reg     <= '0;
      cap_uns_reg      <= 1'b0;
      cap_off_reg      <= '0;
      rd_addr_out      <= '0;
      wr_en_out        <= 1'b0;
      rd_out           <= '0;
      stall_out        <= 1'b0;
      misalign_err_out <= 1'b0;
      timeout_err_out  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      cap_rd_reg       <= cap_rd_next;
      cap_wr_reg       <= cap_wr_next;
      cap_size_reg     <= cap_size_next;
      cap_uns_reg      <= cap_uns_next;
      cap_off_reg      <= cap_off_next;
      rd_addr_out      <= rd_addr_next;
      wr_en_out        <= wr_en_next;
      rd_out           <= rd_next;
      stall_out        <= stall_next;
      misalign_err_out <= misalign_next;
      timeout_err_out  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_msrv32_writeback_unit.sv
// Bench for msrv32_writeback_unit: vector table plus hand sequences; output events are
// checked against a scoreboard queue of expected events tagged with their due clock edge.
module tb_msrv32_writeback_unit;

  localparam int TIMEOUT = 16;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        valid_in;
  logic [4:0]  rd_addr_in;
  logic        rf_wr_en_in;
  logic [31:0] alu_result_in;
  logic        is_load_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic        flush_in;
  logic        mem_ready_in;
  logic [31:0] mem_rdata_in;
  logic [4:0]  rd_addr_out;
  logic        wr_en_out;
  logic [31:0] rd_out;
  logic        stall_out;
  logic        misalign_err_out;
  logic        timeout_err_out;

  msrv32_writeback_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .valid_in(valid_in), .rd_addr_in(rd_addr_in),
    .rf_wr_en_in(rf_wr_en_in), .alu_result_in(alu_result_in), .is_load_in(is_load_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in), .flush_in(flush_in),
    .mem_ready_in(mem_ready_in), .mem_rdata_in(mem_rdata_in), .rd_addr_out(rd_addr_out),
    .wr_en_out(wr_en_out), .rd_out(rd_out), .stall_out(stall_out),
    .misalign_err_out(misalign_err_out), .timeout_err_out(timeout_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          due;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
    logic        tout;
  } exp_t;

  typedef struct {
    logic        is_load;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          delay;
    logic        exp_mis;
    logic [31:0] exp_rd;
  } vec_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int due, input logic wr, input logic [4:0] addr,
                      input logic [31:0] data, input logic mis, input logic tout);
    exp_t e;
    e.due = due; e.wr = wr; e.addr = addr; e.data = data; e.mis = mis; e.tout = tout;
    sb.push_back(e);
  endtask

  // Monitor: every output event must match the oldest expected event, on its due edge.
  always begin
    exp_t e;
    @(posedge clk_in);
    cyc++;
    #1;
    if (wr_en_out || misalign_err_out || timeout_err_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: wr_en=%0b mis=%0b tout=%0b rd_addr=%0d rd=0x%08h edge %0d",
                 wr_en_out, misalign_err_out, timeout_err_out, rd_addr_out, rd_out, cyc);
      end else begin
        e = sb.pop_front();
        check("event_edge", cyc, e.due);
        check("wr_en", {31'd0, wr_en_out}, {31'd0, e.wr});
        check("misalign_err", {31'd0, misalign_err_out}, {31'd0, e.mis});
        check("timeout_err", {31'd0, timeout_err_out}, {31'd0, e.tout});
        if (e.wr) begin
          check("rd_addr", {27'd0, rd_addr_out}, {27'd0, e.addr});
          check("rd_data", rd_out, e.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    valid_in = 1'b0; rd_addr_in = '0; rf_wr_en_in = 1'b0; alu_result_in = '0;
    is_load_in = 1'b0; load_size_in = '0; load_unsigned_in = 1'b0; flush_in = 1'b0;
    mem_ready_in = 1'b0; mem_rdata_in = '0;
  endtask

  // All drive tasks start just after a falling edge and return just after one.
  task automatic alu(input logic [4:0] rd, input logic wr, input logic [31:0] res);
    valid_in = 1'b1; is_load_in = 1'b0; rd_addr_in = rd; rf_wr_en_in = wr; alu_result_in = res;
    if (wr && rd != 5'd0) push(cyc + 1, 1'b1, rd, res, 1'b0, 1'b0);
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic wr, input logic [31:0] addr,
                            input logic [1:0] size, input logic uns);
    valid_in = 1'b1; is_load_in = 1'b1; rd_addr_in = rd; rf_wr_en_in = wr;
    alu_result_in = addr; load_size_in = size; load_unsigned_in = uns;
    @(negedge clk_in);
    valid_in = 1'b0; is_load_in = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (!v.is_load) begin
      alu(v.rd, v.wr, v.addr);
    end else if (v.exp_mis) begin
      push(cyc + 1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      issue_load(v.rd, v.wr, v.addr, v.size, v.uns);
      check("stall_after_misalign", {31'd0, stall_out}, 32'd0);
    end else begin
      issue_load(v.rd, v.wr, v.addr, v.size, v.uns);
      for (int k = 0; k < v.delay; k++) begin
        check("stall_wait", {31'd0, stall_out}, 32'd1);
        if (k != v.delay - 1) @(negedge clk_in);
      end
      mem_ready_in = 1'b1; mem_rdata_in = v.rdata;
      if (v.wr && v.rd != 5'd0) push(cyc + 1, 1'b1, v.rd, v.exp_rd, 1'b0, 1'b0);
      @(negedge clk_in);
      mem_ready_in = 1'b0; mem_rdata_in = '0;
      check("stall_released", {31'd0, stall_out}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    // is_load rd wr addr/result size uns rdata delay exp_mis exp_rd
    vecs[0]  = '{1'b0, 5'd5,  1'b1, 32'h1234_5678, 2'b00, 1'b0, 32'h0,         0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  1'b1, 32'h0000_DEAD, 2'b00, 1'b0, 32'h0,         0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 5'd9,  1'b0, 32'h0000_BEEF, 2'b00, 1'b0, 32'h0,         0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 5'd3,  1'b1, 32'h0000_1003, 2'b00, 1'b0, 32'h80FF_0000, 3, 1'b0, 32'hFFFF_FF80};
    vecs[4]  = '{1'b1, 5'd4,  1'b1, 32'h0000_1003, 2'b00, 1'b1, 32'h80FF_0000, 3, 1'b0, 32'h0000_0080};
    vecs[5]  = '{1'b1, 5'd6,  1'b1, 32'h0000_2001, 2'b01, 1'b0, 32'h0,         0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 5'd0,  1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'hCAFE_BABE, 1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 5'd10, 1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h8001_7FFF, 2, 1'b0, 32'hFFFF_8001};
    vecs[8]  = '{1'b1, 5'd11, 1'b1, 32'h0000_2000, 2'b01, 1'b1, 32'h1234_F00D, 1, 1'b0, 32'h0000_F00D};
    vecs[9]  = '{1'b1, 5'd12, 1'b1, 32'h0000_1001, 2'b00, 1'b0, 32'h0000_7F00, 2, 1'b0, 32'h0000_007F};
    vecs[10] = '{1'b1, 5'd13, 1'b1, 32'h0000_3004, 2'b10, 1'b0, 32'h8765_4321, 4, 1'b0, 32'h8765_4321};
    vecs[11] = '{1'b1, 5'd14, 1'b1, 32'h0000_3002, 2'b10, 1'b0, 32'h0,         0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 5'd15, 1'b1, 32'h0000_0000, 2'b11, 1'b0, 32'h0,         0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 5'd31, 1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0,         0, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 5'd16, 1'b1, 32'h0000_0002, 2'b00, 1'b1, 32'hAA55_0000, 1, 1'b0, 32'h0000_0055};

    idle_inputs();
    reset_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    check("reset_rd_addr", {27'd0, rd_addr_out}, 32'd0);
    check("reset_wr_en", {31'd0, wr_en_out}, 32'd0);
    check("reset_rd", rd_out, 32'd0);
    check("reset_stall", {31'd0, stall_out}, 32'd0);
    check("reset_misalign", {31'd0, misalign_err_out}, 32'd0);
    check("reset_timeout", {31'd0, timeout_err_out}, 32'd0);
    reset_in = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // LW to x7 that never gets data: abandoned after TIMEOUT wait cycles.
    push(cyc + 1 + TIMEOUT, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    issue_load(5'd7, 1'b1, 32'h0000_4000, 2'b10, 1'b0);
    for (int k = 0; k < TIMEOUT; k++) begin
      check("stall_until_timeout", {31'd0, stall_out}, 32'd1);
      @(negedge clk_in);
    end
    check("stall_after_timeout", {31'd0, stall_out}, 32'd0);

    // Flush and mem_ready together while waiting: no write, back to IDLE.
    issue_load(5'd7, 1'b1, 32'h0000_4000, 2'b10, 1'b0);
    flush_in = 1'b1; mem_ready_in = 1'b1; mem_rdata_in = 32'h1111_2222;
    @(negedge clk_in);
    flush_in = 1'b0; mem_ready_in = 1'b0; mem_rdata_in = '0;
    check("stall_after_flush", {31'd0, stall_out}, 32'd0);
    alu(5'd6, 1'b1, 32'h0BAD_F00D);
    // ALU op accepted together with flush is dropped.
    flush_in = 1'b1;
    valid_in = 1'b1; rd_addr_in = 5'd8; rf_wr_en_in = 1'b1; alu_result_in = 32'h5555_5555;
    @(negedge clk_in);
    idle_inputs();

    // Asynchronous reset while a load is waiting.
    issue_load(5'd8, 1'b1, 32'h0000_0000, 2'b10, 1'b0);
    @(negedge clk_in);
    reset_in = 1'b1;
    #1;
    check("midwait_reset_stall", {31'd0, stall_out}, 32'd0);
    check("midwait_reset_rd", rd_out, 32'd0);
    check("midwait_reset_rd_addr", {27'd0, rd_addr_out}, 32'd0);
    check("midwait_reset_wr_en", {31'd0, wr_en_out}, 32'd0);
    @(negedge clk_in);
    reset_in = 1'b0;
    alu(5'd5, 1'b1, 32'h0000_A5A5);
    @(negedge clk_in);
    @(negedge clk_in);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
